sobel_edge_stream: RTL and testbench
====================================

// Module: sobel_edge_stream
// PURPOSE
//  Parametrised next-generation Sobel edge engine: accepts a valid/ready YUV pixel stream and extracts Y.
//  Builds a 3x3 window from two internal line buffers and computes |Gx|+|Gy|.
//  Emits one YUV pixel per input pixel (same frame size) with border handling, runtime mode, SOF/EOL sideband
//  and an end-of-frame flush. Sits between the input YUV FIFO and the output FIFO in the edge pipeline.
// PARAMETERS
//  IMG_W  640  pixels per line (>=4)
//  IMG_H  480  lines per frame (>=3)
//  PIX_W  8    bits per channel; pixel bus is 3*PIX_W, order {Y,U,V}
// PORTS
//  clk        in   1        clock
//  rst_n      in   1        asynchronous active-low reset
//  threshold  in   PIX_W    binary-mode threshold, sampled at accepted SOF
//  mode       in   2        sobel_mode_e, sampled at accepted SOF
//  in_data    in   3*PIX_W  input YUV pixel
//  in_sof     in   1        first pixel of frame (with in_valid)
//  in_valid   in   1        input pixel valid
//  in_ready   out  1        input pixel accepted when in_valid&&in_ready
//  out_data   out  3*PIX_W  {edge_Y, 2^(PIX_W-1), 2^(PIX_W-1)}
//  out_sof    out  1        first output pixel of frame
//  out_eol    out  1        last pixel of each output line
//  out_valid  out  1        output valid
//  out_ready  in   1        downstream ready
//  sof_err    out  1        sticky: in_sof seen mid-frame; cleared only by reset
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_sof=0, out_eol=0, sof_err=0, in_ready=0, counters 0, window 0.
//    FSM=WAIT_SOF. Line buffers need no reset.
//  Advance: adv = !out_valid || out_ready.
//    Output register loads on adv && step; out_valid drops when out_ready && !step.
//  FSM:
//    WAIT_SOF: in_ready=adv. Pixels without in_sof are dropped (no output). Accepted SOF -> RUN,
//      latches threshold/mode, (x,y)=(0,0).
//    RUN: in_ready=adv. Each accept shifts window/line buffers and increments (x,y); x wraps at IMG_W-1.
//      Accepted in_sof with (x,y)!=(0,0) -> sof_err=1; counters restart at (0,0) treating it as a new frame;
//      window and pending outputs are discarded.
//      After pixel (IMG_W-1,IMG_H-1) is accepted -> FLUSH.
//    FLUSH: in_ready=0. IMG_W+1 internal steps (one per adv), each shifting zero input -> WAIT_SOF.
//  Output order: center (cx,cy) is produced on the step after input (cx+1,cy+1), in raster order.
//    First output is on the step after input (1,1) (linear index IMG_W+1).
//    The total is exactly IMG_W*IMG_H outputs per frame, with the last one in FLUSH.
//  Border: cx==0, cx==IMG_W-1, cy==0 or cy==IMG_H-1 -> edge_Y=0. Window taps from the previous or next line
//    across a wrap are never used for interior pixels.
//  Arithmetic:
//    Gx = (a13+2a23+a33)-(a11+2a21+a31); Gy = (a31+2a32+a33)-(a11+2a12+a13).
//    Both are signed PIX_W+3. mag = |Gx|+|Gy| is unsigned PIX_W+3 with no overflow.
//    MODE_BIN: edge_Y = (mag > threshold) ? all-ones : 0.
//    MODE_BIN_INV: edge_Y = the inverse of MODE_BIN.
//    MODE_MAG: edge_Y = min(mag, 2^PIX_W-1).
//    MODE_PASS: edge_Y = a22 (bypass, same latency).
//  out_sof=1 with center (0,0); out_eol=1 with cx==IMG_W-1.
//  out_data/out_sof/out_eol are held stable while out_valid && !out_ready.
//  Latency (no stall): 1 clk from the accept of input (cx+1,cy+1) to out_valid.
//  Throughput: 1 pixel/clk. A new SOF may be accepted in the same cycle the last FLUSH step completes.
// STRUCTURE
//  sobel_pkg: typedef enum logic[1:0] sobel_mode_e {MODE_BIN=0, MODE_MAG=1, MODE_BIN_INV=2, MODE_PASS=3};
//    sobel_fsm_e {WAIT_SOF, RUN, FLUSH}; function chroma_mid(PIX_W).
//  Sub-module sobel_linebuf2 #(IMG_W,PIX_W): two cascaded single-port-per-cycle delay lines.
//    Write at wr_en, outputs line0 (1 line ago) and line1 (2 lines ago).
//  Window regs, counters, FSM, gradient and output register are in this module.
// TESTING (bench IMG_W=8, IMG_H=6, PIX_W=8)
//  1 Flat frame, all Y=100, MODE_MAG, out_ready=1 -> 48 outputs, all Y=0, U=V=128;
//    out_sof on the 1st, out_eol every 8th.
//  2 Vertical step (Y=0 for x<4, 255 for x>=4), MODE_MAG -> interior x=3,4 give Y=255 (mag 1020 clipped);
//    other interior pixels Y=0.
//  3 Same step, MODE_BIN, threshold=200 -> interior x=3,4 give 255, the rest 0.
//    threshold=255 in MODE_BIN_INV -> x=3,4 give 0.
//  4 Random pixels with random out_ready and in_valid toggles -> output sequence identical to the stall-free
//    golden model; data held stable during stalls.
//  5 SOF after 20 pixels -> sof_err=1, the next 48 outputs match a fresh frame, no stale pixels.
//    Pixels without SOF in WAIT_SOF produce nothing.
//  6 Assert rst_n low mid-frame then release -> all outputs at reset values, FSM in WAIT_SOF;
//    the next frame is correct.

Source files
------------

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared mode/state types and chroma helper for the Sobel edge engine
package sobel_pkg;
    typedef enum logic [1:0] {
        MODE_BIN     = 2'd0,
        MODE_MAG     = 2'd1,
        MODE_BIN_INV = 2'd2,
        MODE_PASS    = 2'd3
    } sobel_mode_e;
    typedef enum logic [1:0] {WAIT_SOF, RUN, FLUSH} sobel_fsm_e;
    function automatic logic [31:0] chroma_mid(input int pix_w);
        return 32'd1 << (pix_w - 1);
    endfunction
endpackage

// File: rtl/sobel_edge_stream_if.sv
// sobel_edge_stream_if: input and output pixel stream handshakes of the Sobel engine
interface sobel_edge_stream_if #(parameter int PIX_W = 8);
    logic [3*PIX_W-1:0] in_data;
    logic               in_sof;
    logic               in_valid;
    logic               in_ready;
    logic [3*PIX_W-1:0] out_data;
    logic               out_sof;
    logic               out_eol;
    logic               out_valid;
    logic               out_ready;
    modport master (
        output in_data, in_sof, in_valid, out_ready,
        input  in_ready, out_data, out_sof, out_eol, out_valid
    );
    modport slave (
        input  in_data, in_sof, in_valid, out_ready,
        output in_ready, out_data, out_sof, out_eol, out_valid
    );
endinterface

// File: rtl/sobel_linebuf2.sv
// sobel_linebuf2: two cascaded one-line delay lines giving the pixels one and two lines above
module sobel_linebuf2 #(
    parameter int IMG_W = 640,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] line0,
    output logic [PIX_W-1:0] line1
);
    localparam int AW = $clog2(IMG_W);
    localparam logic [AW-1:0] P_LAST = AW'(IMG_W - 1);
    logic [PIX_W-1:0] mem0 [IMG_W];
    logic [PIX_W-1:0] mem1 [IMG_W];
    logic [AW-1:0]    ptr;
    assign line0 = mem0[ptr];
    assign line1 = mem1[ptr];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr <= '0;
        else if (wr_en) ptr <= (ptr == P_LAST) ? '0 : ptr + AW'(1);
    always_ff @(posedge clk)
        if (wr_en) begin
            mem0[ptr] <= din;
            mem1[ptr] <= mem0[ptr];
        end
endmodule

// File: rtl/sobel_edge_stream.sv
// sobel_edge_stream: streaming 3x3 Sobel |Gx|+|Gy| engine over a valid/ready YUV pixel stream
module sobel_edge_stream import sobel_pkg::*; #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIX_W-1:0]   threshold,
    input  sobel_mode_e        mode,
    sobel_edge_stream_if.slave s,
    output logic               sof_err
);
    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [XW-1:0] X_FLUSH = XW'(IMG_W);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [PIX_W-1:0] MID = PIX_W'(chroma_mid(PIX_W));
    localparam logic [PIX_W-1:0] ONES = '1;
    sobel_fsm_e state, state_nx;
    sobel_mode_e mode_q;
    logic [PIX_W-1:0] thr_q, din, l0, l1, edge_y;
    logic [PIX_W-1:0] w [3][2];
    logic [XW-1:0] x, ox;
    logic [YW-1:0] y, oy;
    logic live, adv, acc, sof_take, step, emit, flush_step, last_flush, border, bin, unused_uv;
    logic signed [PIX_W+2:0] gx, gy;
    logic [PIX_W+2:0] mag;
    function automatic logic [PIX_W+2:0] wsum(input logic [PIX_W-1:0] a, b, c);
        return {3'b0, a} + {2'b0, b, 1'b0} + {3'b0, c};
    endfunction
    assign unused_uv  = ^s.in_data[2*PIX_W-1:0];
    assign adv        = !s.out_valid || s.out_ready;
    assign acc        = s.in_valid && s.in_ready;
    assign sof_take   = acc && s.in_sof;
    assign last_flush = state == FLUSH && x == X_FLUSH;
    assign flush_step = state == FLUSH && adv;
    assign step       = flush_step || sof_take || (acc && state == RUN);
    // centre (cx,cy) is complete once input (cx+1,cy+1) arrives; flush supplies the tail
    assign emit = flush_step || (acc && !s.in_sof && state == RUN &&
                  (y > YW'(1) || (y == YW'(1) && x != '0)));
    assign din  = acc ? s.in_data[3*PIX_W-1 -: PIX_W] : '0;
    sobel_linebuf2 #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lb (
        .clk(clk), .rst_n(rst_n), .wr_en(step), .din(din), .line0(l0), .line1(l1)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= WAIT_SOF;
        else state <= state_nx;
    always_comb begin
        state_nx   = state;
        s.in_ready = live && adv && (state != FLUSH || last_flush);
        if (sof_take) state_nx = RUN;
        else if (state == RUN && acc && x == X_LAST && y == Y_LAST) state_nx = FLUSH;
        else if (last_flush && adv) state_nx = WAIT_SOF;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            live    <= 1'b0;
            x       <= '0;
            y       <= '0;
            ox      <= '0;
            oy      <= '0;
            mode_q  <= MODE_BIN;
            thr_q   <= '0;
            sof_err <= 1'b0;
        end else begin
            live <= 1'b1;
            if (emit) begin
                ox <= (ox == X_LAST) ? '0 : ox + XW'(1);
                oy <= (ox == X_LAST) ? oy + YW'(1) : oy;
            end
            if (sof_take) begin
                x       <= XW'(1);
                y       <= '0;
                ox      <= '0;
                oy      <= '0;
                mode_q  <= mode;
                thr_q   <= threshold;
                sof_err <= sof_err || state == RUN;
            end else if (flush_step) x <= x + XW'(1);
            else if (acc && state == RUN) begin
                x <= (x == X_LAST) ? '0 : x + XW'(1);
                y <= (x == X_LAST) ? y + YW'(1) : y;
            end
        end
    // w holds the left and centre columns; the right column is {l1, l0, din}
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                w[r][0] <= '0;
                w[r][1] <= '0;
            end
        end else if (step) begin
            for (int r = 0; r < 3; r++) w[r][0] <= sof_take ? '0 : w[r][1];
            w[0][1] <= l1;
            w[1][1] <= l0;
            w[2][1] <= din;
        end
    assign gx     = $signed(wsum(l1, l0, din) - wsum(w[0][0], w[1][0], w[2][0]));
    assign gy     = $signed(wsum(w[2][0], w[2][1], din) - wsum(w[0][0], w[0][1], l1));
    assign mag    = (gx[PIX_W+2] ? $unsigned(-gx) : $unsigned(gx)) + (gy[PIX_W+2] ? $unsigned(-gy) : $unsigned(gy));
    assign bin    = mag > {3'b0, thr_q};
    assign border = ox == '0 || ox == X_LAST || oy == '0 || oy == Y_LAST;
    assign edge_y = border ? '0 :
                    mode_q == MODE_PASS ? w[1][1] :
                    mode_q == MODE_MAG ? (mag > {3'b0, ONES} ? ONES : mag[PIX_W-1:0]) :
                    (bin ^ (mode_q == MODE_BIN_INV)) ? ONES : '0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s.out_valid <= 1'b0;
            s.out_data  <= '0;
            s.out_sof   <= 1'b0;
            s.out_eol   <= 1'b0;
        end else if (emit) begin
            s.out_valid <= 1'b1;
            s.out_data  <= {edge_y, MID, MID};
            s.out_sof   <= ox == '0 && oy == '0;
            s.out_eol   <= ox == X_LAST;
        end else if (s.out_ready) s.out_valid <= 1'b0;
endmodule

// File: tb/tb_sobel_edge_stream.sv
// tb_sobel_edge_stream: table-driven and randomized frame checks against a 2D-array Sobel reference
module tb_sobel_edge_stream;
    import sobel_pkg::*;
    localparam int W = 8, H = 6, P = 8;
    typedef struct {logic [23:0] d; logic sof; sobel_mode_e m; logic [7:0] t;} beat_t;
    typedef struct {logic [7:0] y; logic sof; logic eol;} exp_t;
    typedef struct {int pat; sobel_mode_e m; logic [7:0] t; int rdy; int vld; int e_edge; int e_flat;} row_t;
    logic clk = 0, rst_n = 0, sof_err;
    logic [7:0] threshold;
    sobel_mode_e mode;
    sobel_edge_stream_if #(.PIX_W(P)) bus();
    sobel_edge_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
        .clk(clk), .rst_n(rst_n), .threshold(threshold), .mode(mode), .s(bus), .sof_err(sof_err)
    );
    always #5 clk = ~clk;
    logic [7:0] img [H][W];
    beat_t inq[$];
    exp_t expq[$];
    int tests = 0, fails = 0, nout = 0;
    logic held_ok = 0;
    logic [25:0] held;
    row_t rows [10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic make_img(input int pat);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = pat == 0 ? 8'd100 : pat == 1 ? (c < 4 ? 8'd0 : 8'd255) : 8'($urandom_range(255));
    endtask

    function automatic bit is_border(input int cx, input int cy);
        return cx == 0 || cx == W - 1 || cy == 0 || cy == H - 1;
    endfunction

    function automatic int ref_y(input int cx, input int cy, input sobel_mode_e m, input logic [7:0] t);
        int gx = 0, gy = 0, mag;
        if (is_border(cx, cy)) return 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
                int v = int'(img[cy+dy][cx+dx]);
                gx += dx * (dy == 0 ? 2 : 1) * v;
                gy += dy * (dx == 0 ? 2 : 1) * v;
            end
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        case (m)
            MODE_BIN:     return mag > int'(t) ? 255 : 0;
            MODE_BIN_INV: return mag > int'(t) ? 0 : 255;
            MODE_MAG:     return mag > 255 ? 255 : mag;
            default:      return int'(img[cy][cx]);
        endcase
    endfunction

    task automatic push_frame(input sobel_mode_e m, input logic [7:0] t, input int n_pix, input int n_out,
                              input int e_edge, input int e_flat);
        for (int i = 0; i < n_pix; i++)
            inq.push_back('{d: {img[i/W][i%W], 16'($urandom)}, sof: i == 0,
                            m: i == 0 ? m : sobel_mode_e'(2'($urandom)), t: i == 0 ? t : 8'($urandom)});
        for (int c = 0; c < n_out; c++) begin
            int cx = c % W, cy = c / W, yv;
            yv = e_edge < 0 ? ref_y(cx, cy, m, t) : is_border(cx, cy) ? 0 : (cx == 3 || cx == 4) ? e_edge : e_flat;
            expq.push_back('{y: 8'(yv), sof: c == 0, eol: cx == W - 1});
        end
    endtask

    task automatic push_junk(input int n);
        for (int i = 0; i < n; i++)
            inq.push_back('{d: 24'($urandom), sof: 1'b0, m: MODE_MAG, t: 8'd0});
    endtask

    task automatic tick(input int rdy, input int vld);
        exp_t e;
        logic [25:0] want;
        @(negedge clk);
        bus.out_ready = $urandom_range(99) < rdy;
        if (inq.size() > 0 && $urandom_range(99) < vld) begin
            bus.in_valid = 1; bus.in_data = inq[0].d; bus.in_sof = inq[0].sof;
            mode = inq[0].m; threshold = inq[0].t;
        end else begin
            bus.in_valid = 0; bus.in_sof = 1'($urandom); bus.in_data = 24'($urandom);
            mode = sobel_mode_e'(2'($urandom)); threshold = 8'($urandom);
        end
        #1;
        if (held_ok) begin
            tests++;
            if (!bus.out_valid || {bus.out_data, bus.out_sof, bus.out_eol} !== held) begin
                fails++;
                $display("FAIL hold got v=%b %h want v=1 %h", bus.out_valid, {bus.out_data, bus.out_sof, bus.out_eol}, held);
            end
        end
        held_ok = bus.out_valid && !bus.out_ready;
        held = {bus.out_data, bus.out_sof, bus.out_eol};
        if (bus.out_valid && bus.out_ready) begin
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL extra_out got %h want no output", bus.out_data);
            end else begin
                e = expq.pop_front();
                want = {e.y, 8'd128, 8'd128, e.sof, e.eol};
                if ({bus.out_data, bus.out_sof, bus.out_eol} !== want) begin
                    fails++;
                    $display("FAIL out[%0d] got data=%h sof=%b eol=%b want data=%h sof=%b eol=%b", nout,
                             bus.out_data, bus.out_sof, bus.out_eol, want[25:2], want[1], want[0]);
                end
            end
            nout++;
        end
        if (bus.in_valid && bus.in_ready) void'(inq.pop_front());
    endtask

    task automatic drain(input int rdy, input int vld);
        int budget = 3000;
        while ((inq.size() > 0 || expq.size() > 0) && budget > 0) begin
            tick(rdy, vld);
            budget--;
        end
        chk("drain_left", inq.size() + expq.size(), 0);
        inq.delete();
        expq.delete();
    endtask

    task automatic reset_checks();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_sof", bus.out_sof, 0);
        chk("rst_eol", bus.out_eol, 0);
        chk("rst_sof_err", sof_err, 0);
        chk("rst_in_ready", bus.in_ready, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        rows[0] = '{0, MODE_MAG,     8'd0,   100, 100, 0,   0};
        rows[1] = '{1, MODE_MAG,     8'd0,   100, 100, 255, 0};
        rows[2] = '{1, MODE_BIN,     8'd200, 100, 100, 255, 0};
        rows[3] = '{1, MODE_BIN_INV, 8'd255, 100, 100, 0,   255};
        rows[4] = '{0, MODE_PASS,    8'd0,   100, 100, 100, 100};
        rows[5] = '{1, MODE_MAG,     8'd0,   60,  70,  255, 0};
        rows[6] = '{2, MODE_MAG,     8'd0,   50,  60,  -1,  0};
        rows[7] = '{2, MODE_BIN,     8'd180, 70,  50,  -1,  0};
        rows[8] = '{2, MODE_BIN_INV, 8'd90,  40,  80,  -1,  0};
        rows[9] = '{2, MODE_PASS,    8'd0,   80,  40,  -1,  0};
        bus.in_valid = 0; bus.in_sof = 0; bus.in_data = 0; bus.out_ready = 0;
        mode = MODE_BIN; threshold = 0;
        repeat (3) @(negedge clk);
        #1 reset_checks();
        @(negedge clk) rst_n = 1;
        @(posedge clk) #1 chk("post_rst_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            make_img(rows[i].pat);
            push_frame(rows[i].m, rows[i].t, W * H, W * H, rows[i].e_edge, rows[i].e_flat);
            drain(rows[i].rdy, rows[i].vld);
        end
        chk("no_sof_err", sof_err, 0);
        make_img(2);
        push_frame(MODE_MAG, 8'd0, 20, 11, -1, 0);
        make_img(2);
        push_frame(MODE_MAG, 8'd0, W * H, W * H, -1, 0);
        drain(70, 80);
        chk("sof_err_set", sof_err, 1);
        push_junk(5);
        make_img(2);
        push_frame(MODE_BIN, 8'd120, W * H, W * H, -1, 0);
        drain(90, 90);
        make_img(2);
        push_frame(MODE_BIN, 8'd50, 30, 21, -1, 0);
        drain(80, 80);
        @(negedge clk);
        bus.out_ready = 0; bus.in_valid = 1; bus.in_sof = 0; bus.in_data = {img[3][6], 16'h0};
        @(negedge clk);
        bus.in_valid = 0;
        #1 chk("pre_rst_valid", bus.out_valid, 1);
        rst_n = 0;
        held_ok = 0;
        #1 reset_checks();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(posedge clk) #1 chk("rerst_in_ready", bus.in_ready, 1);
        chk("rerst_valid", bus.out_valid, 0);
        push_junk(4);
        make_img(2);
        push_frame(MODE_MAG, 8'd0, W * H, W * H, -1, 0);
        drain(75, 75);
        chk("final_sof_err", sof_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
